// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one single-port synchronous data memory between the CPU
//             load/store path and an external host port. CPU has priority;
//             define DMEM_ARB_AGE_EN to add an aging guard for the ext port.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 4
) (
    input  logic              sysclk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_adr_i,
    input  logic [31:0]       cpu_wd_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [31:0]       cpu_rd_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_adr_i,
    input  logic [31:0]       ext_wd_i,
    output logic              ext_gnt_o,
    output logic              ext_rvalid_o,
    output logic [31:0]       ext_rd_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i
);

    localparam logic [0:0] c_phase_req  = 1'b0;
    localparam logic [0:0] c_phase_data = 1'b1;

    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_cpu  = 2'd1;
    localparam logic [1:0] c_own_ext  = 2'd2;

    logic [0:0] r_cpu_phase;
    logic [0:0] w_cpu_phase_nxt;
    logic [1:0] r_rd_owner;
    logic [1:0] w_rd_owner_nxt;

    logic w_cpu_want;
    logic w_ext_force;
    logic w_gnt_cpu;
    logic w_gnt_ext;

    // A CPU request seen during its DATA cycle belongs to the finished read.
    assign w_cpu_want = cpu_req_i && (r_cpu_phase == c_phase_req);
    assign w_gnt_cpu  = w_cpu_want && !(ext_req_i && w_ext_force);
    assign w_gnt_ext  = ext_req_i && !w_gnt_cpu;

`ifdef DMEM_ARB_AGE_EN
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_cnt_nxt;

    assign w_ext_force = (r_wait_cnt == c_max_wait);

    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!ext_req_i || w_gnt_ext) begin
            w_wait_cnt_nxt = 4'd0;
        end else if (r_wait_cnt != c_max_wait) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!reset_i) begin
            r_wait_cnt <= 4'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`else
    // Strict CPU priority; only a degenerate zero wait limit would favour ext.
    assign w_ext_force = (MAX_WAIT == 0);
`endif

    // State register
    always_ff @(posedge sysclk_i) begin
        if (!reset_i) begin
            r_cpu_phase <= c_phase_req;
            r_rd_owner  <= c_own_none;
        end else begin
            r_cpu_phase <= w_cpu_phase_nxt;
            r_rd_owner  <= w_rd_owner_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_cpu_phase_nxt = c_phase_req;
        w_rd_owner_nxt  = c_own_none;
        if (w_gnt_cpu && !cpu_we_i) begin
            w_cpu_phase_nxt = c_phase_data;
            w_rd_owner_nxt  = c_own_cpu;
        end else if (w_gnt_ext && !ext_we_i) begin
            w_rd_owner_nxt  = c_own_ext;
        end
    end

    // Output logic
    always_comb begin
        mem_we_o     = 1'b0;
        mem_adr_o    = '0;
        mem_wd_o     = '0;
        cpu_stall_o  = 1'b0;
        cpu_rvalid_o = 1'b0;
        cpu_rd_o     = '0;
        ext_rvalid_o = 1'b0;
        ext_rd_o     = '0;
        ext_gnt_o    = w_gnt_ext;

        if (w_gnt_cpu) begin
            mem_we_o  = cpu_we_i;
            mem_adr_o = cpu_adr_i;
            mem_wd_o  = cpu_wd_i;
        end else if (w_gnt_ext) begin
            mem_we_o  = ext_we_i;
            mem_adr_o = ext_adr_i;
            mem_wd_o  = ext_wd_i;
        end

        if (w_cpu_want && !(w_gnt_cpu && cpu_we_i)) begin
            cpu_stall_o = 1'b1;
        end

        if (r_rd_owner == c_own_cpu) begin
            cpu_rvalid_o = 1'b1;
            cpu_rd_o     = mem_rd_i;
        end
        if (r_rd_owner == c_own_ext) begin
            ext_rvalid_o = 1'b1;
            ext_rd_o     = mem_rd_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Randomised scoreboard bench for dmem_arbiter with a word-level
//             reference memory and arbitration model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W    = 14;
    localparam int MAX_WAIT  = 4;
    localparam int MEM_WORDS = 256;
`ifdef DMEM_ARB_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic              sysclk_i = 1'b0;
    logic              reset_i  = 1'b0;
    logic              cpu_req_i = 1'b0;
    logic              cpu_we_i  = 1'b0;
    logic [ADDR_W-1:0] cpu_adr_i = '0;
    logic [31:0]       cpu_wd_i  = '0;
    logic              cpu_stall_o;
    logic              cpu_rvalid_o;
    logic [31:0]       cpu_rd_o;
    logic              ext_req_i = 1'b0;
    logic              ext_we_i  = 1'b0;
    logic [ADDR_W-1:0] ext_adr_i = '0;
    logic [31:0]       ext_wd_i  = '0;
    logic              ext_gnt_o;
    logic              ext_rvalid_o;
    logic [31:0]       ext_rd_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_adr_o;
    logic [31:0]       mem_wd_o;
    logic [31:0]       mem_rd_i = '0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .sysclk_i     (sysclk_i),
        .reset_i      (reset_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_adr_i    (cpu_adr_i),
        .cpu_wd_i     (cpu_wd_i),
        .cpu_stall_o  (cpu_stall_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rd_o     (cpu_rd_o),
        .ext_req_i    (ext_req_i),
        .ext_we_i     (ext_we_i),
        .ext_adr_i    (ext_adr_i),
        .ext_wd_i     (ext_wd_i),
        .ext_gnt_o    (ext_gnt_o),
        .ext_rvalid_o (ext_rvalid_o),
        .ext_rd_o     (ext_rd_o),
        .mem_we_o     (mem_we_o),
        .mem_adr_o    (mem_adr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    always #5 sysclk_i = ~sysclk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    initial forever begin
        @(posedge sysclk_i);
        cyc++;
    end

    // Single-port synchronous memory, one cycle read latency
    logic [31:0] mem [MEM_WORDS];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = pat(i);
        forever begin
            @(posedge sysclk_i);
            mem_rd_i <= mem[mem_adr_o[7:0]];
            if (mem_we_o) mem[mem_adr_o[7:0]] <= mem_wd_o;
        end
    end

    // Reference model: decides who owns the bus this cycle from the rules
    typedef struct { logic [31:0] d; int due; } exp_t;
    exp_t cpu_q[$];
    exp_t ext_q[$];
    logic [31:0] shadow [MEM_WORDS];
    bit m_data = 1'b0;
    int m_wait = 0;
    bit m_cpu_done = 1'b0;
    bit m_ext_gnt  = 1'b0;
    bit aged, e_cpu, e_ext, e_stall, e_we;
    logic [ADDR_W-1:0] e_adr;
    logic [31:0] e_wd;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) shadow[i] = pat(i);
        forever begin
            @(negedge sysclk_i);
            aged    = AGE && (m_wait >= MAX_WAIT);
            e_cpu   = cpu_req_i && !m_data && !(ext_req_i && aged);
            e_ext   = ext_req_i && !e_cpu;
            e_stall = cpu_req_i && !m_data && !(e_cpu && cpu_we_i);
            e_we = 1'b0; e_adr = '0; e_wd = '0;
            if (e_cpu) begin
                e_we = cpu_we_i; e_adr = cpu_adr_i; e_wd = cpu_wd_i;
            end else if (e_ext) begin
                e_we = ext_we_i; e_adr = ext_adr_i; e_wd = ext_wd_i;
            end
            if (armed) begin
                chk("ext_gnt", ext_gnt_o, e_ext);
                chk("cpu_stall", cpu_stall_o, e_stall);
                chk("mem_we", mem_we_o, e_we);
                chk("mem_adr", mem_adr_o, e_adr);
                chk("mem_wd", mem_wd_o, e_wd);
            end
            m_cpu_done = cpu_req_i && (m_data || (e_cpu && cpu_we_i));
            m_ext_gnt  = e_ext;
            if (e_we) shadow[e_adr[7:0]] = e_wd;
            else if (reset_i && e_cpu) cpu_q.push_back('{shadow[e_adr[7:0]], cyc + 1});
            else if (reset_i && e_ext) ext_q.push_back('{shadow[e_adr[7:0]], cyc + 1});
            if (!reset_i) begin
                m_data = 1'b0;
                m_wait = 0;
            end else begin
                m_data = e_cpu && !cpu_we_i;
                if (ext_req_i && !e_ext) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
                else m_wait = 0;
            end
        end
    end

    // Response monitors
    exp_t mon_c;
    exp_t mon_e;
    initial forever begin
        @(negedge sysclk_i);
        if (armed) begin
            if (cpu_rvalid_o) begin
                if (cpu_q.size() == 0) chk("cpu_rvalid", cpu_rvalid_o, 1'b0);
                else begin
                    mon_c = cpu_q.pop_front();
                    chk("cpu_rvalid_cycle", cyc, mon_c.due);
                    chk("cpu_rd", cpu_rd_o, mon_c.d);
                end
            end else begin
                chk("cpu_rd_idle", cpu_rd_o, 32'h0);
                if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                    chk("cpu_rvalid", cpu_rvalid_o, 1'b1);
                    void'(cpu_q.pop_front());
                end
            end
        end
    end
    initial forever begin
        @(negedge sysclk_i);
        if (armed) begin
            if (ext_rvalid_o) begin
                if (ext_q.size() == 0) chk("ext_rvalid", ext_rvalid_o, 1'b0);
                else begin
                    mon_e = ext_q.pop_front();
                    chk("ext_rvalid_cycle", cyc, mon_e.due);
                    chk("ext_rd", ext_rd_o, mon_e.d);
                end
            end else begin
                chk("ext_rd_idle", ext_rd_o, 32'h0);
                if (ext_q.size() != 0 && ext_q[0].due <= cyc) begin
                    chk("ext_rvalid", ext_rvalid_o, 1'b1);
                    void'(ext_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic cpu_access(input bit we, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_adr_i = a; cpu_wd_i = d;
        do begin
            tick();
            n++;
        end while (!m_cpu_done && n < 20);
        chk("cpu_access_done", 32'(m_cpu_done), 32'h1);
        cpu_req_i = 1'b0;
    endtask

    int first_gnt;

    initial begin
        // Reset held two cycles while a CPU read is being issued
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 14'h0005;
        tick();
        armed = 1'b1;
        tick();
        reset_i = 1'b1; cpu_req_i = 1'b0; cpu_adr_i = '0;
        @(negedge sysclk_i);
        chk("rst_cpu_stall", cpu_stall_o, 1'b0);
        chk("rst_cpu_rvalid", cpu_rvalid_o, 1'b0);
        chk("rst_cpu_rd", cpu_rd_o, 32'h0);
        chk("rst_ext_gnt", ext_gnt_o, 1'b0);
        chk("rst_ext_rvalid", ext_rvalid_o, 1'b0);
        chk("rst_ext_rd", ext_rd_o, 32'h0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_adr", mem_adr_o, 14'h0);
        chk("rst_mem_wd", mem_wd_o, 32'h0);
        tick();

        // CPU write then read back
        cpu_access(1'b1, 14'h0010, 32'hDEAD_BEEF);
        cpu_access(1'b0, 14'h0010, 32'h0);
        tick();

        // Ext back-to-back reads with CPU idle
        ext_req_i = 1'b1; ext_we_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ext_adr_i = ADDR_W'(i);
            tick();
        end
        ext_req_i = 1'b0;
        tick(); tick();

        // Simultaneous writes: CPU first, ext next cycle
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 14'h0020; cpu_wd_i = 32'hC0DE_0001;
        ext_req_i = 1'b1; ext_we_i = 1'b1; ext_adr_i = 14'h0021; ext_wd_i = 32'hE0DE_0002;
        tick();
        cpu_req_i = 1'b0;
        tick();
        ext_req_i = 1'b0;
        tick(); tick();
        chk("contend_mem_cpu", mem[32'h20], 32'hC0DE_0001);
        chk("contend_mem_ext", mem[32'h21], 32'hE0DE_0002);

        // Aging: CPU writes continuously while ext holds a read
        first_gnt = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 14'h0040; cpu_wd_i = 32'hA0A0_A0A0;
        ext_req_i = 1'b1; ext_we_i = 1'b0; ext_adr_i = 14'h0007;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sysclk_i);
            if (ext_gnt_o && first_gnt == 0) first_gnt = k;
            tick();
            if (first_gnt != 0) ext_req_i = 1'b0;
        end
        chk("age_first_gnt", first_gnt, AGE ? 32'd5 : 32'd0);
        cpu_req_i = 1'b0; ext_req_i = 1'b0;
        tick(); tick();

        // Ext write overlapping the CPU read DATA cycle
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 14'h0030;
        tick();
        ext_req_i = 1'b1; ext_we_i = 1'b1; ext_adr_i = 14'h0030; ext_wd_i = 32'h1234_5678;
        @(negedge sysclk_i);
        chk("data_cycle_ext_gnt", ext_gnt_o, 1'b1);
        chk("data_cycle_mem_we", mem_we_o, 1'b1);
        tick();
        cpu_req_i = 1'b0; ext_req_i = 1'b0;
        tick();
        cpu_access(1'b0, 14'h0030, 32'h0);
        tick();

        // Randomised traffic with occasional reset pulses
        repeat (3000) begin
            if (!cpu_req_i || m_cpu_done) begin
                cpu_req_i = ($urandom_range(0, 9) < 7);
                cpu_we_i  = 1'($urandom_range(0, 1));
                cpu_adr_i = ADDR_W'($urandom_range(0, 63));
                cpu_wd_i  = $urandom;
            end
            if (!ext_req_i || m_ext_gnt) begin
                ext_req_i = 1'($urandom_range(0, 1));
                ext_we_i  = 1'($urandom_range(0, 1));
                ext_adr_i = ADDR_W'($urandom_range(0, 63));
                ext_wd_i  = $urandom;
            end
            reset_i = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_i = 1'b1; cpu_req_i = 1'b0; ext_req_i = 1'b0;
        tick(); tick(); tick();
        chk("cpu_q_drained", cpu_q.size(), 32'd0);
        chk("ext_q_drained", ext_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port synchronous data memory between the CPU load/store path and an external port (program loader / debug / trace host). It sits between the CPU's memory-access outputs (ALU-result word address, rD2 write data, mem write enable) and the dmem instance. It serialises accesses, returns read data after the memory's one-cycle latency, and stalls the CPU while the bus is busy. The CPU has priority; the external port is protected from starvation by an optional aging guard.

## Interface
- ADDR_W, 14, word-address width (matches adr[15:2] word addressing)
- MAX_WAIT, 4, cycles the external port may wait before forced grant (aging build only), range 1..15
- sysclk_i  input  1  clock, all state on rising edge
- reset_i  input  1  synchronous, active-low reset
- cpu_req_i  input  1  CPU access request, held stable until completion
- cpu_we_i  input  1  1 = write, 0 = read
- cpu_adr_i  input  ADDR_W  CPU word address
- cpu_wd_i  input  32  CPU write data
- cpu_stall_o  output  1  CPU must hold PC/state this cycle
- cpu_rvalid_o  output  1  cpu_rd_o valid this cycle
- cpu_rd_o  output  32  CPU read data
- ext_req_i  input  1  external request
- ext_we_i  input  1  external write
- ext_adr_i  input  ADDR_W  external word address
- ext_wd_i  input  32  external write data
- ext_gnt_o  output  1  external request accepted this cycle
- ext_rvalid_o  output  1  ext_rd_o valid this cycle
- ext_rd_o  output  32  external read data
- mem_we_o  output  1  dmem write enable
- mem_adr_o  output  ADDR_W  dmem address
- mem_wd_o  output  32  dmem write data
- mem_rd_i  input  32  dmem read data, valid one cycle after address

## Operation
- Bus owner is chosen combinationally each cycle. The chosen port's we/adr/wd drive mem_*. When no port is granted, mem_we_o=0, mem_adr_o=0, mem_wd_o=0.
- Registered read tag rd_owner ∈ {NONE, CPU, EXT} records which port issued a read last cycle. It routes mem_rd_i to cpu_rd_o or ext_rd_o and raises the matching rvalid.
- CPU phase register cpu_phase ∈ {REQ, DATA}:
  - REQ, read granted: stall=1, next state DATA.
  - DATA: cpu_rvalid_o=1, stall=0, next state REQ. cpu_req_i in this cycle belongs to the completed read and is not re-issued. The bus is free for ext.
  - REQ, write granted: stall=0, single cycle, state stays REQ.
  - REQ, not granted: stall=1.
- Priority when both request in the same cycle: CPU wins, unless the aging guard is active (see Configuration).
- External port:
  - ext_gnt_o=1 means the access was issued this cycle.
  - For reads, ext_rvalid_o=1 the next cycle.
  - Back-to-back ext requests are accepted every cycle the bus is free.
- Read data is never held beyond its rvalid cycle. The rd outputs are 0 when their rvalid is 0.

## Timing
- Reset (reset_i=0 at clock edge): rd_owner=NONE, cpu_phase=REQ, wait counter=0. All outputs are 0 in the cycle after reset. Any read in flight is dropped and produces no rvalid.
- CPU write: 0 stall cycles when uncontended.
- CPU read: exactly 1 stall cycle when uncontended, with data in the following cycle.
- Contention adds 1 stall cycle per external grant.
- External read latency: ext_gnt_o in cycle N, then ext_rvalid_o in cycle N+1.
- Simultaneous CPU DATA cycle and ext request: ext is granted in the same cycle (no conflict).
- cpu_req_i deasserted in REQ: no access, stall=0.

## Configuration
- DMEM_ARB_AGE_EN defined:
  - A 4-bit wait counter increments each cycle where ext_req_i=1 and ext_gnt_o=0, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, ext wins the next contended arbitration, and the CPU stalls that cycle.
  - The counter clears on ext_gnt_o or when ext_req_i=0.
- DMEM_ARB_AGE_EN undefined: strict CPU priority, no counter logic, and ext may starve indefinitely.

## Test plan
- Reset: hold reset_i=0 for 2 cycles while CPU read is in flight → no rvalid. All outputs are 0 in the cycle after release.
- CPU write 0xDEADBEEF to word 0x0010, then read 0x0010 → write has stall=0. Read has stall for 1 cycle, then cpu_rvalid_o=1 and cpu_rd_o=0xDEADBEEF.
- Ext back-to-back reads of 0x0001, 0x0002, 0x0003 with CPU idle → ext_gnt_o=1 for 3 consecutive cycles. rvalid on the next 3 cycles, with data in order.
- Contention: CPU and ext both request a write in the same cycle → CPU written first, ext_gnt_o the next cycle, and both words correct in memory.
- Aging (DMEM_ARB_AGE_EN, MAX_WAIT=4): CPU requests continuously, ext holds a read → ext_gnt_o on the 5th cycle and CPU stall=1 that cycle. Without the macro, ext_gnt_o never asserts.
- CPU read DATA cycle overlapping an ext write → ext_gnt_o=1 and mem_we_o=1 in that cycle. cpu_rd_o still returns the pre-write data.
